// File: rtl/alu_result_packetizer.sv
// alu_result_packetizer: captures one ALU result plus opcode, frames it as a 4-byte header
// (opcode, reserved, 16-bit length LE) followed by a little-endian payload, and streams the
// packet one byte at a time over a ready/valid interface. Only one result is held at a time.
// Optional feature macro: RESULT_CHECKSUM_EN appends an XOR checksum byte to each packet.
module alu_result_packetizer #(
  parameter logic [7:0] HDR_RSVD = 8'h00,
  parameter logic [7:0] OpAdd    = 8'h02,
  parameter logic [7:0] OpMul    = 8'h03,
  parameter logic [7:0] OpDiv    = 8'h04
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  opcode_i,
  input  logic [63:0] result_i,
  input  logic        result_valid_i,
  output logic        result_ready_o,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        drop_o,
  output logic        busy_o,
  output logic [2:0]  state_o
);

  // Encodings double as the debug state_o values.
  typedef enum logic [2:0] {
    StIdle     = 3'd1,
    StHeader   = 3'd2,
`ifdef RESULT_CHECKSUM_EN
    StPayload  = 3'd3,
    StChecksum = 3'd4
`else
    StPayload  = 3'd3
`endif
  } state_e;

`ifdef RESULT_CHECKSUM_EN
  localparam logic [15:0] ExtraLen = 16'd1;
`else
  localparam logic [15:0] ExtraLen = 16'd0;
`endif

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d, idx_nxt;
  logic [7:0]  opcode_q, opcode_d;
  logic [63:0] result_q, result_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        drop_q, drop_d;
  logic        is_mul;
  logic [2:0]  last_idx;
  logic [15:0] pkt_len;
  logic        accept, handshake, supported;
`ifdef RESULT_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  assign result_ready_o = (state_q == StIdle) && !rst;
  assign accept         = result_valid_i && result_ready_o;
  assign handshake      = valid_q && ready_i;
  assign supported      = (opcode_i == OpAdd) || (opcode_i == OpMul) || (opcode_i == OpDiv);

  // Packet geometry is derived from the latched opcode so input changes after accept are inert.
  assign is_mul   = (opcode_q == OpMul);
  assign last_idx = is_mul ? 3'd7 : 3'd3;
  assign pkt_len  = (is_mul ? 16'd12 : 16'd8) + ExtraLen;
  assign idx_nxt  = idx_q + 3'd1;

  // Next-state, next-byte and latch update logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    opcode_d = opcode_q;
    result_d = result_q;
    data_d   = data_q;
    valid_d  = valid_q;
    drop_d   = 1'b0;
`ifdef RESULT_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          opcode_d = opcode_i;
          result_d = result_i;
          if (supported) begin
            state_d = StHeader;
            idx_d   = 3'd0;
            // b0 comes straight from the input so it is on the wire the cycle after accept.
            data_d  = opcode_i;
            valid_d = 1'b1;
`ifdef RESULT_CHECKSUM_EN
            csum_d  = 8'h00;
`endif
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      StHeader: begin
        if (handshake) begin
`ifdef RESULT_CHECKSUM_EN
          csum_d = csum_q ^ data_q;
`endif
          if (idx_q == 3'd3) begin
            state_d = StPayload;
            idx_d   = 3'd0;
            data_d  = result_q[7:0];
          end else begin
            idx_d = idx_nxt;
            case (idx_q)
              3'd0:    data_d = HDR_RSVD;
              3'd1:    data_d = pkt_len[7:0];
              default: data_d = pkt_len[15:8];
            endcase
          end
        end
      end
      StPayload: begin
        if (handshake) begin
          if (idx_q == last_idx) begin
            idx_d = 3'd0;
`ifdef RESULT_CHECKSUM_EN
            state_d = StChecksum;
            data_d  = csum_q ^ data_q;
`else
            state_d = StIdle;
            valid_d = 1'b0;
`endif
          end else begin
            idx_d  = idx_nxt;
            data_d = result_q[{idx_nxt, 3'b000} +: 8];
`ifdef RESULT_CHECKSUM_EN
            csum_d = csum_q ^ data_q;
`endif
          end
        end
      end
`ifdef RESULT_CHECKSUM_EN
      StChecksum: begin
        if (handshake) begin
          state_d = StIdle;
          idx_d   = 3'd0;
          valid_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d = StIdle;
        idx_d   = 3'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= 3'd0;
      opcode_q <= 8'h00;
      result_q <= 64'h0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      drop_q   <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
      csum_q   <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      opcode_q <= opcode_d;
      result_q <= result_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      drop_q   <= drop_d;
`ifdef RESULT_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign drop_o  = drop_q;
  assign busy_o  = (state_q != StIdle);
  assign state_o = state_q;

endmodule

// File: doc/alu_result_packetizer.md
# alu_result_packetizer

Downstream neighbour of the command FSM/ALU. Captures one ALU result word with its opcode, frames it into a response packet (4 header bytes plus little-endian payload bytes), and streams it one byte at a time over a ready/valid byte interface toward the UART transmitter. Holds exactly one result in flight; upstream is back-pressured until the last byte is accepted.

## Interface
- HDR_RSVD, 8'h00, value sent in header byte 1 (reserved field)
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- opcode_i  in  8  opcode of the result (ECHO/ADD/MUL/DIV encodings from config_pkg); sampled with result
- result_i  in  64  ALU result; sampled on accept
- result_valid_i  in  1  result/opcode valid from ALU
- result_ready_o  out  1  block can accept a result
- data_o  out  8  response byte to UART TX
- valid_o  out  1  data_o valid
- ready_i  in  1  UART TX accepts byte
- drop_o  out  1  one-cycle pulse: accepted result had unsupported opcode and was discarded
- busy_o  out  1  packet in progress (state != IDLE)
- state_o  out  3  debug: IDLE=1, HEADER=2, PAYLOAD=3, CHECKSUM=4

## Operation
- Accept = result_valid_i & result_ready_o. result_ready_o = 1 only in IDLE (not during reset).
- On accept: latch opcode_i, result_i; payload count P = 4 for ADD and DIV (result_i[31:0]), 8 for MUL (result_i[63:0]). Any other opcode (including ECHO): no packet, drop_o = 1 next cycle, stay IDLE.
- Packet length L = 4 + P (+1 with checksum), 16-bit, counts header bytes, matching the FSM's length convention.
- Byte order: b0 opcode, b1 HDR_RSVD, b2 L[7:0], b3 L[15:8], then payload bytes LSB first (result[7:0] first).
- States: IDLE -> HEADER on supported accept; HEADER (byte index 0..3) -> PAYLOAD after b3 handshake; PAYLOAD (index 0..P-1) -> IDLE after last payload handshake (or -> CHECKSUM when enabled); CHECKSUM -> IDLE after its handshake.
- Byte index counter advances only on valid_o & ready_i; reset to 0 on every state change.
- data_o/valid_o are registered; data_o stable while valid_o & !ready_i (AXI-style: valid never drops without handshake).
- Reset values: result_ready_o 0 during rst then 1; data_o 8'h00; valid_o 0; drop_o 0; busy_o 0; state_o IDLE; all latches 0.

## Timing
- Accept in cycle N -> valid_o = 1 with b0 in cycle N+1.
- With ready_i held high: one byte per cycle; 8-byte packet (ADD) occupies N+1..N+8; valid_o low in N+9, result_ready_o high in N+9 (one idle cycle between packets).
- ready_i low: current byte held indefinitely, no index advance.
- result_valid_i while busy: ignored (not accepted), no loss; upstream must hold it.
- drop_o: asserted cycle N+1 only; result_ready_o stays high so a new result may be accepted in N+1.
- rst asserted mid-packet: next cycle valid_o = 0, state IDLE, partial packet abandoned, no drop_o.
- Payload selection uses latched values; opcode_i/result_i changes after accept have no effect.

## Configuration
- RESULT_CHECKSUM_EN defined: CHECKSUM state compiled in; one trailing byte = XOR of all preceding packet bytes (b0..last payload); L includes it (ADD: L=9, MUL: L=13).
- Not defined: no CHECKSUM state; PAYLOAD -> IDLE directly; ADD L=8, MUL L=12; state_o never 4.

## Test plan
- ADD opcode, result_i = 64'h0000_0000_DEAD_BEEF, ready_i=1 -> bytes ADD, 00, 08, 00, EF, BE, AD, DE on consecutive cycles starting N+1; result_ready_o low N+1..N+8.
- MUL, result_i = 64'h0123_4567_89AB_CDEF -> L=12 (byte2 0x0C), payload EF CD AB 89 67 45 23 01; with RESULT_CHECKSUM_EN, L=13 and trailing byte equals XOR of first 12 bytes.
- Random ready_i stalls (~50%) during DIV packet -> data_o constant while valid_o & !ready_i; byte sequence identical to unstalled run.
- ECHO or opcode 8'hFF accepted -> drop_o one-cycle pulse at N+1, valid_o never asserted, result_ready_o high throughout.
- Second result_valid_i held during packet -> accepted only in first IDLE cycle after last byte; both packets complete, one idle cycle between.
- rst pulse after byte 5 of MUL packet -> valid_o 0 next cycle, busy_o 0, next ADD result produces clean full packet.
